// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised raster timing generator with run enable,
// line-compare strobe and delayed sync outputs for pixel pipelines.
module vga_timing_gen #(
   parameter int CW       = 12,
   parameter int H_ACTIVE = 1280,
   parameter int H_FP     = 48,
   parameter int H_SYNC   = 112,
   parameter int H_BP     = 248,
   parameter int V_ACTIVE = 1024,
   parameter int V_FP     = 1,
   parameter int V_SYNC   = 3,
   parameter int V_BP     = 38,
   parameter int H_POL    = 1,
   parameter int V_POL    = 1,
   parameter int SYNC_DLY = 0
) (
   input  logic          clk_dot,
   input  logic          reset,
   input  logic          en,
   input  logic [CW-1:0] line_cmp,
   output logic          vid_new_frame,
   output logic          vid_new_line,
   output logic          vid_active,
   output logic [CW-1:0] x_cnt,
   output logic [CW-1:0] y_cnt,
   output logic          line_irq,
   output logic          vga_hsync,
   output logic          vga_vsync
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
   localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
   localparam logic [CW-1:0] H_ACT  = CW'(H_ACTIVE);
   localparam logic [CW-1:0] V_ACT  = CW'(V_ACTIVE);
   localparam logic [CW-1:0] HS_BEG = CW'(H_ACTIVE + H_FP);
   localparam logic [CW-1:0] HS_END = CW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CW-1:0] VS_BEG = CW'(V_ACTIVE + V_FP);
   localparam logic [CW-1:0] VS_END = CW'(V_ACTIVE + V_FP + V_SYNC);

   localparam logic HS_ON = (H_POL != 0);
   localparam logic VS_ON = (V_POL != 0);

   localparam bit LEGAL =
      (H_ACTIVE >= 1) && (H_FP >= 1) && (H_SYNC >= 1) && (H_BP >= 1) &&
      (V_ACTIVE >= 1) && (V_FP >= 1) && (V_SYNC >= 1) && (V_BP >= 1) &&
      (H_TOTAL <= (1 << CW)) && (V_TOTAL <= (1 << CW)) &&
      (SYNC_DLY >= 0) && (SYNC_DLY <= 15);

   logic [CW-1:0] h;
   logic [CW-1:0] v;
   logic          hs_q;
   logic          vs_q;

   // Outputs are decoded from the current (h,v), so they lag the counters
   // by one clock and stay coherent with x_cnt/y_cnt.
   always_ff @(posedge clk_dot or posedge reset) begin
      if (reset) begin
         h             <= '0;
         v             <= '0;
         x_cnt         <= '0;
         y_cnt         <= '0;
         vid_new_frame <= 1'b0;
         vid_new_line  <= 1'b0;
         vid_active    <= 1'b0;
         line_irq      <= 1'b0;
         hs_q          <= ~HS_ON;
         vs_q          <= ~VS_ON;
      end else if (!en) begin
         h             <= '0;
         v             <= '0;
         x_cnt         <= '0;
         y_cnt         <= '0;
         vid_new_frame <= 1'b0;
         vid_new_line  <= 1'b0;
         vid_active    <= 1'b0;
         line_irq      <= 1'b0;
         hs_q          <= ~HS_ON;
         vs_q          <= ~VS_ON;
      end else begin
         x_cnt         <= h;
         y_cnt         <= v;
         vid_new_frame <= (h == '0) && (v == '0);
         vid_new_line  <= (h == '0);
         vid_active    <= (h < H_ACT) && (v < V_ACT);
         line_irq      <= (h == H_ACT) && (v == line_cmp);
         hs_q <= ((h >= HS_BEG) && (h < HS_END)) ? HS_ON : ~HS_ON;
         vs_q <= ((v >= VS_BEG) && (v < VS_END)) ? VS_ON : ~VS_ON;
         if (h == H_LAST) begin
            h <= '0;
            v <= (v == V_LAST) ? '0 : v + 1'b1;
         end else begin
            h <= h + 1'b1;
         end
      end
   end

   generate
      if (SYNC_DLY == 0) begin : g_nodly
         assign vga_hsync = hs_q;
         assign vga_vsync = vs_q;
      end else begin : g_dly
         logic [SYNC_DLY-1:0] hs_p;
         logic [SYNC_DLY-1:0] vs_p;

         // Keeps shifting while disabled so the pipe drains to idle.
         always_ff @(posedge clk_dot or posedge reset) begin
            if (reset) begin
               hs_p <= {SYNC_DLY{~HS_ON}};
               vs_p <= {SYNC_DLY{~VS_ON}};
            end else begin
               hs_p[0] <= hs_q;
               vs_p[0] <= vs_q;
               for (int i = 1; i < SYNC_DLY; i++) begin
                  hs_p[i] <= hs_p[i-1];
                  vs_p[i] <= vs_p[i-1];
               end
            end
         end

         assign vga_hsync = hs_p[SYNC_DLY-1];
         assign vga_vsync = vs_p[SYNC_DLY-1];
      end
   endgenerate

   always_ff @(posedge clk_dot) begin
      assert (LEGAL)
         else $error("vga_timing_gen: illegal timing parameters");
   end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: directed checks of small, inverted/delayed and
// default timing, line compare, enable gaps and async reset.
module tb_vga_timing_gen;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic [11:0] line_cmp;

   logic        nf0, nl0, act0, irq0, hs0, vs0;
   logic [11:0] x0, y0;
   logic        nf1, nl1, act1, irq1, hs1, vs1;
   logic [11:0] x1, y1;
   logic        nf2, nl2, act2, irq2, hs2, vs2;
   logic [11:0] x2, y2;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   vga_timing_gen #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
   ) dut0 (
      .clk_dot(clk), .reset(rst), .en(en), .line_cmp(line_cmp),
      .vid_new_frame(nf0), .vid_new_line(nl0), .vid_active(act0),
      .x_cnt(x0), .y_cnt(y0), .line_irq(irq0),
      .vga_hsync(hs0), .vga_vsync(vs0)
   );

   vga_timing_gen #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
      .H_POL(0), .V_POL(0), .SYNC_DLY(3)
   ) dut1 (
      .clk_dot(clk), .reset(rst), .en(en), .line_cmp(line_cmp),
      .vid_new_frame(nf1), .vid_new_line(nl1), .vid_active(act1),
      .x_cnt(x1), .y_cnt(y1), .line_irq(irq1),
      .vga_hsync(hs1), .vga_vsync(vs1)
   );

   vga_timing_gen dut2 (
      .clk_dot(clk), .reset(rst), .en(en), .line_cmp(line_cmp),
      .vid_new_frame(nf2), .vid_new_line(nl2), .vid_active(act2),
      .x_cnt(x2), .y_cnt(y2), .line_irq(irq2),
      .vga_hsync(hs2), .vga_vsync(vs2)
   );

   // Reset pulse then enable; the next posedge evaluates h=0,v=0.
   task automatic start();
      @(negedge clk);
      rst = 1'b1;
      en  = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      en  = 1'b1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      @(negedge clk);
      checks++;
      if ({x0,y0,nf0,nl0,act0,irq0,hs0,vs0} !== 30'd0) begin
         failures++;
         $display("FAIL reset_d0 got=%h want=%h",
                  {x0,y0,nf0,nl0,act0,irq0,hs0,vs0}, 30'd0);
      end
      checks++;
      if ({x1,y1,nf1,nl1,act1,irq1,hs1,vs1} !== 30'd3) begin
         failures++;
         $display("FAIL reset_d1 got=%h want=%h",
                  {x1,y1,nf1,nl1,act1,irq1,hs1,vs1}, 30'd3);
      end
      checks++;
      if ({x2,y2,nf2,nl2,act2,irq2,hs2,vs2} !== 30'd0) begin
         failures++;
         $display("FAIL reset_d2 got=%h want=%h",
                  {x2,y2,nf2,nl2,act2,irq2,hs2,vs2}, 30'd0);
      end
   endtask

   task automatic test_small();
      int h, v, s, s3, hh, vv, irqs, frames;
      logic eh, ev, dh, dv;
      logic [29:0] want, got;
      start();
      line_cmp = 12'd2;
      irqs = 0;
      frames = 0;
      for (int k = 1; k <= 300; k++) begin
         @(negedge clk);
         s  = k - 1;
         h  = s % 16;
         v  = (s / 16) % 8;
         eh = (h >= 10) && (h < 13);
         ev = (v >= 5) && (v < 7);
         want = {12'(h), 12'(v), (h == 0) && (v == 0), h == 0,
                 (h < 8) && (v < 4), (v == 2) && (h == 8), eh, ev};
         got = {x0,y0,nf0,nl0,act0,irq0,hs0,vs0};
         checks++;
         if (got !== want) begin
            failures++;
            $display("FAIL small k=%0d got=%h want=%h", k, got, want);
         end
         s3 = k - 4;
         dh = 1'b1;
         dv = 1'b1;
         if (s3 >= 0) begin
            hh = s3 % 16;
            vv = (s3 / 16) % 8;
            dh = !((hh >= 10) && (hh < 13));
            dv = !((vv >= 5) && (vv < 7));
         end
         want[1] = dh;
         want[0] = dv;
         got = {x1,y1,nf1,nl1,act1,irq1,hs1,vs1};
         checks++;
         if (got !== want) begin
            failures++;
            $display("FAIL dly3 k=%0d got=%h want=%h", k, got, want);
         end
         if (irq0) irqs++;
         if (nf0) frames++;
      end
      checks++;
      if (irqs !== 3) begin
         failures++;
         $display("FAIL irq_count got=%0d want=3", irqs);
      end
      checks++;
      if (frames !== 3) begin
         failures++;
         $display("FAIL frame_count got=%0d want=3", frames);
      end
   endtask

   task automatic test_line_none();
      int irqs;
      start();
      line_cmp = 12'd9;
      irqs = 0;
      for (int k = 1; k <= 384; k++) begin
         @(negedge clk);
         if (irq0) irqs++;
      end
      checks++;
      if (irqs !== 0) begin
         failures++;
         $display("FAIL irq_none got=%0d want=0", irqs);
      end
   endtask

   task automatic test_default();
      int h, v, s, lines;
      logic [29:0] want, got;
      start();
      line_cmp = 12'd1;
      lines = 0;
      for (int k = 1; k <= 3400; k++) begin
         @(negedge clk);
         s = k - 1;
         h = s % 1688;
         v = s / 1688;
         want = {12'(h), 12'(v), (h == 0) && (v == 0), h == 0,
                 (h < 1280) && (v < 1024), (v == 1) && (h == 1280),
                 (h >= 1328) && (h < 1440), (v >= 1025) && (v < 1028)};
         got = {x2,y2,nf2,nl2,act2,irq2,hs2,vs2};
         checks++;
         if (got !== want) begin
            failures++;
            $display("FAIL dflt k=%0d got=%h want=%h", k, got, want);
         end
         if (nl2) lines++;
      end
      checks++;
      if (lines !== 3) begin
         failures++;
         $display("FAIL dflt_lines got=%0d want=3", lines);
      end
   endtask

   task automatic test_en_drop();
      start();
      line_cmp = 12'd0;
      for (int k = 1; k <= 38; k++) @(negedge clk);
      checks++;
      if ({x0,y0} !== {12'd5,12'd2}) begin
         failures++;
         $display("FAIL drop_pos got=%h want=%h", {x0,y0}, {12'd5,12'd2});
      end
      en = 1'b0;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         checks++;
         if ({x0,y0,nf0,nl0,act0,irq0,hs0,vs0} !== 30'd0) begin
            failures++;
            $display("FAIL gap_d0 i=%0d got=%h want=0", i,
                     {x0,y0,nf0,nl0,act0,irq0,hs0,vs0});
         end
         checks++;
         if ({x1,y1,nf1,nl1,act1,irq1,hs1,vs1} !== 30'd3) begin
            failures++;
            $display("FAIL gap_d1 i=%0d got=%h want=3", i,
                     {x1,y1,nf1,nl1,act1,irq1,hs1,vs1});
         end
         checks++;
         if ({x2,y2,nf2,nl2,act2,irq2,hs2,vs2} !== 30'd0) begin
            failures++;
            $display("FAIL gap_d2 i=%0d got=%h want=0", i,
                     {x2,y2,nf2,nl2,act2,irq2,hs2,vs2});
         end
      end
      en = 1'b1;
      @(negedge clk);
      checks++;
      if ({x0,y0,nf0,nl0,act0,irq0,hs0,vs0} !== {24'd0,6'b111000}) begin
         failures++;
         $display("FAIL reen got=%h want=%h",
                  {x0,y0,nf0,nl0,act0,irq0,hs0,vs0}, {24'd0,6'b111000});
      end
      @(negedge clk);
      checks++;
      if ({x0,nf0} !== {12'd1,1'b0}) begin
         failures++;
         $display("FAIL reen_next got=%h want=%h", {x0,nf0}, {12'd1,1'b0});
      end
   endtask

   task automatic test_async_reset();
      start();
      for (int k = 1; k <= 12; k++) @(negedge clk);
      checks++;
      if ({x0,hs0} !== {12'd11,1'b1}) begin
         failures++;
         $display("FAIL pre_rst got=%h want=%h", {x0,hs0}, {12'd11,1'b1});
      end
      #2;
      rst = 1'b1;
      #1;
      checks++;
      if ({x0,y0,nf0,nl0,act0,irq0,hs0,vs0} !== 30'd0) begin
         failures++;
         $display("FAIL arst_d0 got=%h want=0",
                  {x0,y0,nf0,nl0,act0,irq0,hs0,vs0});
      end
      checks++;
      if ({x1,y1,nf1,nl1,act1,irq1,hs1,vs1} !== 30'd3) begin
         failures++;
         $display("FAIL arst_d1 got=%h want=3",
                  {x1,y1,nf1,nl1,act1,irq1,hs1,vs1});
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++;
      if ({x0,y0,nf0,nl0,act0,irq0,hs0,vs0} !== {24'd0,6'b111000}) begin
         failures++;
         $display("FAIL arst_restart got=%h want=%h",
                  {x0,y0,nf0,nl0,act0,irq0,hs0,vs0}, {24'd0,6'b111000});
      end
      @(negedge clk);
      checks++;
      if ({x0,nf0} !== {12'd1,1'b0}) begin
         failures++;
         $display("FAIL arst_next got=%h want=%h", {x0,nf0}, {12'd1,1'b0});
      end
   endtask

   initial begin
      rst      = 1'b1;
      en       = 1'b0;
      line_cmp = '0;
      test_reset();
      test_small();
      test_line_none();
      test_default();
      test_en_drop();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
